// File: rtl/pos_sweep_pkg.sv
// Shared definitions for the pos_sweep product-of-sums sweep block.
//   - parameter bound constants MAX_VARS / MAX_TERMS
//   - FSM state encoding (IDLE, LOAD, SWEEP, DONE) as legacy-compatible constants
//   - params_ok(): elaboration-time range check for the top-level parameters
package pos_sweep_pkg;

   localparam int unsigned MAX_VARS  = 8;
   localparam int unsigned MAX_TERMS = 16;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_LOAD  = 2'd1;
   localparam state_t ST_SWEEP = 2'd2;
   localparam state_t ST_DONE  = 2'd3;

   function automatic bit params_ok(input int unsigned n_vars, input int unsigned n_terms);
      return (n_vars >= 1) && (n_vars <= MAX_VARS) && (n_terms >= 1) && (n_terms <= MAX_TERMS);
   endfunction

endpackage

// File: rtl/pos_sweep_maxterm_eval.sv
// Combinational evaluation of one maxterm (OR of selected, optionally complemented literals).
// Ports:
//   care_i  [N_VARS] : 1 = variable v appears in this maxterm
//   neg_i   [N_VARS] : 1 = literal for variable v is complemented
//   x_i     [N_VARS] : input vector
//   term_o           : maxterm value; 0 when no care bit is set
module pos_sweep_maxterm_eval #(
   parameter int unsigned N_VARS = 4
) (
   input  logic [N_VARS-1:0] care_i,
   input  logic [N_VARS-1:0] neg_i,
   input  logic [N_VARS-1:0] x_i,
   output logic              term_o
);

   // x ^ neg yields the literal value; masking by care drops absent variables.
   assign term_o = |((x_i ^ neg_i) & care_i);

endmodule

// File: rtl/pos_sweep.sv
// Product-of-sums evaluator with an exhaustive input sweep over all 2^N_VARS vectors.
// Configuration macro: POS_SWEEP_TABLE_EN builds the truth-table register behind tt_out_o;
// when undefined tt_out_o is tied to zero.
// Ports:
//   clk_i, reset_i        : clock, synchronous active-high reset
//   start_i               : begin a sweep (honoured only in IDLE)
//   term_care_i/term_neg_i: maxterm description, bit [t*N_VARS+v], latched in LOAD
//   out_ready_i           : downstream accepts current beat
//   out_valid_o, x_out_o, y_out_o : streamed vector and function value
//   busy_o                : high in LOAD and SWEEP
//   done_o                : one-cycle pulse after the final beat is accepted
//   zero_count_o          : accepted vectors with y = 0 in current/last sweep
//   tt_out_o              : truth table, bit i = y for x = i
module pos_sweep
   import pos_sweep_pkg::*;
#(
   parameter int unsigned N_VARS  = 4,
   parameter int unsigned N_TERMS = 3
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic                        start_i,
   input  logic [N_TERMS*N_VARS-1:0]   term_care_i,
   input  logic [N_TERMS*N_VARS-1:0]   term_neg_i,
   input  logic                        out_ready_i,
   output logic                        out_valid_o,
   output logic [N_VARS-1:0]           x_out_o,
   output logic                        y_out_o,
   output logic                        busy_o,
   output logic                        done_o,
   output logic [N_VARS:0]             zero_count_o,
   output logic [(2**N_VARS)-1:0]      tt_out_o
);

   localparam int unsigned CfgW = N_TERMS * N_VARS;
   localparam int unsigned TblW = 2 ** N_VARS;
   localparam logic [N_VARS:0] ZcMax = {1'b1, {N_VARS{1'b0}}};

   if (!params_ok(N_VARS, N_TERMS)) begin : g_param_check
      $error("pos_sweep: N_VARS must be 1..8 and N_TERMS 1..16");
   end

   state_t            state_q, state_d;
   logic [CfgW-1:0]   care_q, care_d;
   logic [CfgW-1:0]   neg_q, neg_d;
   logic [N_VARS-1:0] cnt_q, cnt_d;
   logic [N_VARS:0]   zc_q, zc_d;

   logic [N_TERMS-1:0] term_val;
   logic               y;
   logic               accept;
   logic               last;

   for (genvar t = 0; t < N_TERMS; t++) begin : g_term
      pos_sweep_maxterm_eval #(
         .N_VARS (N_VARS)
      ) u_term (
         .care_i (care_q[t*N_VARS +: N_VARS]),
         .neg_i  (neg_q[t*N_VARS +: N_VARS]),
         .x_i    (cnt_q),
         .term_o (term_val[t])
      );
   end

   assign y      = &term_val;
   assign accept = (state_q == ST_SWEEP) && out_ready_i;
   assign last   = &cnt_q;

   always_comb begin
      state_d = state_q;
      care_d  = care_q;
      neg_d   = neg_q;
      cnt_d   = cnt_q;
      zc_d    = zc_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            care_d  = term_care_i;
            neg_d   = term_neg_i;
            cnt_d   = '0;
            zc_d    = '0;
            state_d = ST_SWEEP;
         end
         ST_SWEEP: begin
            if (accept) begin
               if (!y && (zc_q != ZcMax)) zc_d = zc_q + 1'b1;
               // The all-ones vector is terminal; the counter holds rather than wrapping.
               if (last) state_d = ST_DONE;
               else      cnt_d   = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         care_q  <= '0;
         neg_q   <= '0;
         cnt_q   <= '0;
         zc_q    <= '0;
      end else begin
         state_q <= state_d;
         care_q  <= care_d;
         neg_q   <= neg_d;
         cnt_q   <= cnt_d;
         zc_q    <= zc_d;
      end
   end

`ifdef POS_SWEEP_TABLE_EN
   logic [TblW-1:0] tt_q, tt_d;

   always_comb begin
      tt_d = tt_q;
      if (state_q == ST_LOAD)  tt_d = '0;
      else if (accept)         tt_d[cnt_q] = y;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) tt_q <= '0;
      else         tt_q <= tt_d;
   end

   assign tt_out_o = tt_q;
`else
   assign tt_out_o = {TblW{1'b0}};
`endif

   assign out_valid_o  = (state_q == ST_SWEEP);
   assign x_out_o      = cnt_q;
   assign y_out_o      = y;
   assign busy_o       = (state_q == ST_LOAD) || (state_q == ST_SWEEP);
   assign done_o       = (state_q == ST_DONE);
   assign zero_count_o = zc_q;

endmodule

// File: tb/tb_pos_sweep.sv
// Self-checking bench for pos_sweep: a 4-variable/3-term instance and a 3-variable/1-term
// instance. Expected beats are pushed to a scoreboard queue when a sweep is started and
// popped against the accepted beats the DUT streams out.
module tb_pos_sweep;

`ifdef POS_SWEEP_TABLE_EN
   localparam bit TblEn = 1'b1;
`else
   localparam bit TblEn = 1'b0;
`endif

   logic clk;
   logic rst;

   logic        start4, ready4;
   logic [11:0] care4, neg4;
   logic        valid4, y4, busy4, done4;
   logic [3:0]  x4;
   logic [4:0]  zc4;
   logic [15:0] tt4;

   logic        start3, ready3;
   logic [2:0]  care3, neg3;
   logic        valid3, y3, busy3, done3;
   logic [2:0]  x3;
   logic [3:0]  zc3;
   logic [7:0]  tt3;

   pos_sweep #(
      .N_VARS  (4),
      .N_TERMS (3)
   ) u_dut4 (
      .clk_i        (clk),
      .reset_i      (rst),
      .start_i      (start4),
      .term_care_i  (care4),
      .term_neg_i   (neg4),
      .out_ready_i  (ready4),
      .out_valid_o  (valid4),
      .x_out_o      (x4),
      .y_out_o      (y4),
      .busy_o       (busy4),
      .done_o       (done4),
      .zero_count_o (zc4),
      .tt_out_o     (tt4)
   );

   pos_sweep #(
      .N_VARS  (3),
      .N_TERMS (1)
   ) u_dut3 (
      .clk_i        (clk),
      .reset_i      (rst),
      .start_i      (start3),
      .term_care_i  (care3),
      .term_neg_i   (neg3),
      .out_ready_i  (ready3),
      .out_valid_o  (valid3),
      .x_out_o      (x3),
      .y_out_o      (y3),
      .busy_o       (busy3),
      .done_o       (done3),
      .zero_count_o (zc3),
      .tt_out_o     (tt3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] idx;
      logic [4:0] beat;
   } stall_t;

   int n_checks = 0;
   int n_fail   = 0;

   logic [4:0] exp_q[$];
   logic [4:0] obs_q[$];
   stall_t     stall_q[$];
   int         done_cyc;
   int         first_vcyc;
   int         ndone;

   // Reference POS evaluation over explicit literal lists.
   function automatic logic model_y(input logic [7:0] x, input logic [11:0] care,
                                    input logic [11:0] neg, input int nv, input int nt);
      logic yv;
      logic term;
      yv = 1'b1;
      for (int t = 0; t < nt; t++) begin
         term = 1'b0;
         for (int v = 0; v < nv; v++) begin
            if (care[t*nv+v] && (neg[t*nv+v] ? !x[v] : x[v])) term = 1'b1;
         end
         yv = yv & term;
      end
      return yv;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive start for one edge with the given config and fill the scoreboard.
   task automatic start_sweep4(input logic [11:0] care, input logic [11:0] neg);
      tick();
      care4  = care;
      neg4   = neg;
      ready4 = 1'b1;
      start4 = 1'b1;
      exp_q.delete();
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back({4'(i), model_y({4'b0, 4'(i)}, care, neg, 4, 3)});
      end
      tick();
      start4 = 1'b0;
   endtask

   // Collect beats of dut4 cycle by cycle; c = 1 is the cycle after the start edge.
   task automatic collect4(input int mode, input int budget, input bit start_mid,
                           input bit start_done);
      obs_q.delete();
      stall_q.delete();
      done_cyc   = -1;
      first_vcyc = -1;
      ndone      = 0;
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         if (valid4 && first_vcyc < 0) first_vcyc = c;
         if (valid4 && ready4) obs_q.push_back({x4, y4});
         else if (valid4)      stall_q.push_back({8'(obs_q.size()), x4, y4});
         if (done4) begin
            ndone++;
            if (done_cyc < 0) done_cyc = c;
            if (start_done) start4 = 1'b1;
         end
         if (done_cyc >= 0 && c >= done_cyc + 3) break;
         tick();
         start4 = 1'b0;
         if (c == 1) begin
            care4 = 12'($urandom);
            neg4  = 12'($urandom);
         end
         if (start_mid && c == 4) start4 = 1'b1;
         ready4 = (mode == 0) ? 1'b1 : ~ready4;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start4 = 1'b0; ready4 = 1'b0; care4 = 12'hFFF; neg4 = 12'hFFF;
      start3 = 1'b0; ready3 = 1'b0; care3 = 3'b111;  neg3 = 3'b111;
      repeat (3) tick();
      @(negedge clk);
      n_checks++;
      if ({valid4, x4, y4, busy4, done4, zc4, tt4} !== 29'd0) begin
         n_fail++;
         $display("FAIL reset_dut4: got %h want 0", {valid4, x4, y4, busy4, done4, zc4, tt4});
      end
      n_checks++;
      if ({valid3, x3, y3, busy3, done3, zc3, tt3} !== 19'd0) begin
         n_fail++;
         $display("FAIL reset_dut3: got %h want 0", {valid3, x3, y3, busy3, done3, zc3, tt3});
      end
      tick();
      rst = 1'b0;
      tick();
      @(negedge clk);
      n_checks++;
      if ({valid4, busy4, done4, zc4} !== 8'd0) begin
         n_fail++;
         $display("FAIL idle_after_reset: got %h want 0", {valid4, busy4, done4, zc4});
      end
   endtask

   task automatic test_basic();
      logic [4:0] o, e;
      start_sweep4(12'h7DA, 12'h312);
      collect4(0, 40, 1'b0, 1'b0);
      n_checks++;
      if (obs_q.size() != 16) begin
         n_fail++; $display("FAIL basic_beats: got %0d want 16", obs_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL basic_beat: got x=%0d y=%b want x=%0d y=%b",
                                               o[4:1], o[0], e[4:1], e[0]); end
      end
      n_checks++;
      if (first_vcyc != 2) begin
         n_fail++; $display("FAIL basic_first_beat_cycle: got %0d want 2", first_vcyc);
      end
      n_checks++;
      if (done_cyc != 18) begin
         n_fail++; $display("FAIL basic_done_cycle: got %0d want 18", done_cyc);
      end
      n_checks++;
      if (zc4 !== 5'd6) begin n_fail++; $display("FAIL basic_zero_count: got %0d want 6", zc4); end
      n_checks++;
      if (tt4 !== (TblEn ? 16'hF731 : 16'h0000)) begin
         n_fail++; $display("FAIL basic_tt: got %h want %h", tt4, TblEn ? 16'hF731 : 16'h0000);
      end
   endtask

   task automatic test_backpressure();
      logic [4:0] o, e;
      logic [4:0] exp_arr[$];
      start_sweep4(12'h7DA, 12'h312);
      exp_arr = exp_q;
      collect4(1, 70, 1'b0, 1'b0);
      n_checks++;
      if (obs_q.size() != 16) begin
         n_fail++; $display("FAIL bp_beats: got %0d want 16", obs_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL bp_beat: got x=%0d y=%b want x=%0d y=%b",
                                               o[4:1], o[0], e[4:1], e[0]); end
      end
      n_checks++;
      if (stall_q.size() != 16) begin
         n_fail++; $display("FAIL bp_stall_count: got %0d want 16", stall_q.size());
      end
      foreach (stall_q[i]) begin
         if (int'(stall_q[i].idx) < exp_arr.size()) begin
            n_checks++;
            if (stall_q[i].beat !== exp_arr[stall_q[i].idx]) begin
               n_fail++;
               $display("FAIL bp_stall_hold: got x=%0d y=%b want x=%0d y=%b",
                        stall_q[i].beat[4:1], stall_q[i].beat[0],
                        exp_arr[stall_q[i].idx][4:1], exp_arr[stall_q[i].idx][0]);
            end
         end
      end
      n_checks++;
      if (done_cyc != 34) begin
         n_fail++; $display("FAIL bp_done_cycle: got %0d want 34", done_cyc);
      end
      n_checks++;
      if (zc4 !== 5'd6) begin n_fail++; $display("FAIL bp_zero_count: got %0d want 6", zc4); end
   endtask

   task automatic test_all_zero_care();
      logic [4:0] o, e;
      start_sweep4(12'h000, 12'hFFF);
      collect4(0, 40, 1'b0, 1'b0);
      n_checks++;
      if (obs_q.size() != 16) begin
         n_fail++; $display("FAIL zero_beats: got %0d want 16", obs_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL zero_beat: got x=%0d y=%b want x=%0d y=%b",
                                               o[4:1], o[0], e[4:1], e[0]); end
      end
      n_checks++;
      if (zc4 !== 5'd16) begin n_fail++; $display("FAIL zero_count_max: got %0d want 16", zc4); end
      n_checks++;
      if (tt4 !== 16'h0000) begin n_fail++; $display("FAIL zero_tt: got %h want 0000", tt4); end
   endtask

   task automatic test_three_var();
      logic [4:0] e;
      int dc;
      int beats;
      logic [4:0] exp3_q[$];
      tick();
      care3 = 3'b100; neg3 = 3'b000; ready3 = 1'b1; start3 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         exp3_q.push_back({1'b0, 3'(i), model_y({5'b0, 3'(i)}, 12'h004, 12'h000, 3, 1)});
      end
      tick();
      start3 = 1'b0;
      dc = -1;
      beats = 0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (valid3 && ready3) begin
            beats++;
            e = (exp3_q.size() > 0) ? exp3_q.pop_front() : 5'h1F;
            n_checks++;
            if ({1'b0, x3, y3} !== e) begin
               n_fail++;
               $display("FAIL v3_beat: got x=%0d y=%b want x=%0d y=%b", x3, y3, e[3:1], e[0]);
            end
         end
         if (done3) begin dc = c; break; end
         tick();
      end
      n_checks++;
      if (dc != 10 || beats != 8) begin
         n_fail++; $display("FAIL v3_done: got cycle %0d beats %0d want cycle 10 beats 8", dc, beats);
      end
      n_checks++;
      if (zc3 !== 4'd4) begin n_fail++; $display("FAIL v3_zero_count: got %0d want 4", zc3); end
      n_checks++;
      if (tt3 !== (TblEn ? 8'hF0 : 8'h00)) begin
         n_fail++; $display("FAIL v3_tt: got %h want %h", tt3, TblEn ? 8'hF0 : 8'h00);
      end
   endtask

   task automatic test_reset_mid_sweep();
      logic [4:0] o, e;
      bit hit;
      start_sweep4(12'h7DA, 12'h312);
      hit = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (valid4 && x4 == 4'd4) begin hit = 1'b1; break; end
         tick();
      end
      n_checks++;
      if (!hit || zc4 !== 5'd3) begin
         n_fail++; $display("FAIL mid_partial: got reached=%0d zc=%0d want reached=1 zc=3", hit, zc4);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({valid4, x4, y4, busy4, done4, zc4, tt4} !== 29'd0) begin
         n_fail++;
         $display("FAIL mid_reset_outputs: got %h want 0", {valid4, x4, y4, busy4, done4, zc4, tt4});
      end
      // Three identical maxterms x4': y = ~x[0].
      start_sweep4(12'h111, 12'h111);
      collect4(0, 40, 1'b0, 1'b0);
      n_checks++;
      if (obs_q.size() != 16) begin
         n_fail++; $display("FAIL restart_beats: got %0d want 16", obs_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL restart_beat: got x=%0d y=%b want x=%0d y=%b",
                                               o[4:1], o[0], e[4:1], e[0]); end
      end
      n_checks++;
      if (zc4 !== 5'd8) begin n_fail++; $display("FAIL restart_zero_count: got %0d want 8", zc4); end
      n_checks++;
      if (tt4 !== (TblEn ? 16'h5555 : 16'h0000)) begin
         n_fail++; $display("FAIL restart_tt: got %h want %h", tt4, TblEn ? 16'h5555 : 16'h0000);
      end
   endtask

   task automatic test_start_ignored();
      logic [4:0] o, e;
      start_sweep4(12'h7DA, 12'h312);
      collect4(0, 40, 1'b1, 1'b1);
      n_checks++;
      if (obs_q.size() != 16) begin
         n_fail++; $display("FAIL ign_beats: got %0d want 16", obs_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL ign_beat: got x=%0d y=%b want x=%0d y=%b",
                                               o[4:1], o[0], e[4:1], e[0]); end
      end
      n_checks++;
      if (done_cyc != 18 || ndone != 1) begin
         n_fail++;
         $display("FAIL ign_done: got cycle %0d pulses %0d want cycle 18 pulses 1", done_cyc, ndone);
      end
      n_checks++;
      if (busy4 !== 1'b0 || valid4 !== 1'b0) begin
         n_fail++; $display("FAIL ign_no_restart: got busy=%b valid=%b want 0 0", busy4, valid4);
      end
      n_checks++;
      if (zc4 !== 5'd6) begin n_fail++; $display("FAIL ign_zero_count: got %0d want 6", zc4); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_all_zero_care();
      test_three_var();
      test_reset_mid_sweep();
      test_start_ignored();
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pos_sweep.md
# pos_sweep

Parametrised product-of-sums evaluator with an exhaustive input sweep. It holds a run-time-loaded maxterm description of an N-variable Boolean function and steps through all 2^N input vectors. Each vector and its function value stream out over a valid/ready handshake, and the block accumulates a zero count and, optionally, the full truth table. It generalises the fixed gate-level POS circuits of the problem sets into a reusable, self-checking block for lab verification.

## Interface
- N_VARS, 4: number of input variables; legal range 1..8.
- N_TERMS, 3: number of maxterms; legal range 1..16.
- clk in 1: the only clock; all state changes on its rising edge.
- reset in 1: synchronous, active-high.
- start in 1: one-cycle request to latch the configuration and begin a sweep; honoured only in IDLE.
- term_care in N_TERMS*N_VARS: bit [t*N_VARS+v] = 1 means variable v appears in maxterm t.
- term_neg in N_TERMS*N_VARS: bit [t*N_VARS+v] = 1 means that literal is complemented.
- out_ready in 1: downstream accepts the current beat.
- out_valid out 1: x_out/y_out hold a valid beat.
- x_out out N_VARS: current input vector; bit N_VARS-1 is x1 (MSB), bit 0 is xN.
- y_out out 1: function value for x_out.
- busy out 1: high in LOAD and SWEEP.
- done out 1: one-cycle pulse after the final beat is accepted.
- zero_count out N_VARS+1: number of accepted vectors with y_out = 0 in the current or last sweep.
- tt_out out 2^N_VARS: truth table; bit i = y for x = i (see Configuration).

## Operation
- Maxterm t = OR over v with care=1 of (neg ? ~x[v] : x[v]). A term with no care bits evaluates to 0, so f = 0 for every vector.
- y = AND of all N_TERMS maxterm values. y is purely combinational from the latched configuration and the vector counter.
- FSM states:
  - IDLE: start moves to LOAD.
  - LOAD (1 cycle): latch term_care/term_neg, clear counter, zero_count and tt_out; move to SWEEP.
  - SWEEP: out_valid = 1. On out_valid & out_ready, record y and increment the counter. An accepted beat at x = all-ones moves to DONE.
  - DONE (1 cycle): done = 1, then IDLE.
- Configuration inputs are ignored outside LOAD. Changing them mid-sweep has no effect.
- start is ignored in LOAD, SWEEP and DONE.
- zero_count increments on each accepted beat with y = 0. Maximum value is 2^N_VARS and it does not wrap. It holds its value through IDLE until the next LOAD.
- Reset values: state IDLE, out_valid 0, x_out 0, y_out reflects the cleared config (0), busy 0, done 0, zero_count 0, tt_out 0, latched config 0.

## Timing
- start sampled high in IDLE at edge k gives LOAD in cycle k+1 and the first beat (x = 0, out_valid = 1) in cycle k+2.
- One beat per cycle under continuous out_ready. A full sweep takes 2^N_VARS cycles. done asserts the cycle after the final acceptance.
- Back-pressure: while out_valid & !out_ready, x_out and y_out stay stable and no counter advances.
- Counter wrap: the all-ones vector is terminal. The counter never wraps to 0 inside a sweep.
- Reset asserted mid-sweep returns to IDLE on that edge with all outputs at reset values. The partial zero_count is discarded.
- start asserted in the same cycle as done is ignored. A new sweep needs start in IDLE.

## Configuration
- POS_SWEEP_TABLE_EN defined: tt_out[x] is written with y on each accepted beat and holds its value after done until the next LOAD.
- POS_SWEEP_TABLE_EN undefined: no table register is built. tt_out is tied to 0 and the port remains present. zero_count and the stream are unaffected.

## Structure
- Shared package pos_sweep_pkg holds:
  - the state enum (IDLE, LOAD, SWEEP, DONE);
  - the parameter bound constants (MAX_VARS = 8, MAX_TERMS = 16).
- Sub-module maxterm_eval: combinational, one per term via a generate loop. Inputs care, neg and x (N_VARS each); output one term bit.
- The top level contains the FSM, the counter, the AND reduction, the zero counter and the optional table.

## Test plan
- Default params, terms {x1+x3'}, {x1+x2+x4'}, {x2+x3'+x4'}, out_ready tied 1: zero vectors are 1,2,3,6,7,11; zero_count = 6; tt_out = 16'hF731; done 18 cycles after start.
- Same config, out_ready toggling 1-0 every cycle: the same 16 (x, y) pairs arrive in order, each held stable during stalls; final zero_count = 6.
- All care bits 0: y = 0 for every vector; zero_count = 16; tt_out = 0.
- Single term {x1}, N_VARS = 3: zero_count = 4; tt_out = 8'hF0.
- Reset at the 5th beat, then restart with a new config: outputs return to reset values, and the new sweep begins at x = 0 with zero_count counting from 0.
- start pulsed during SWEEP and in the done cycle: no restart, and exactly one done pulse per sweep.
